lsu_dmem_master: RTL and testbench
==================================

# lsu_dmem_master

Load/store initiator for the data memory port: accepts one load or store from the execute stage over a valid/ready handshake, drives the `dmem_*` strobes of the data SRAM, and returns extracted, sign/zero-extended load data or a store completion. Handles byte/half/word sizing, byte-mask generation, write-data replication and misalignment errors. Sits between the EX/MEM pipeline stage and the data SRAM responder, which reads synchronously: read data is registered at the edge that samples `dmem_ren`.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; only 32 is supported.
- One clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_op_i`  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are loads only.
- `req_addr_i`  in  ADDR_W  byte address.
- `req_wdata_i`  in  32  store data, right-aligned.
- `resp_valid_o`  out  1  response valid.
- `resp_ready_i`  in  1  response consumed.
- `resp_rdata_o`  out  32  extended load data; 0 for stores and errors.
- `resp_err_o`  out  1  access error.
- `dmem_ren_o`  out  1  read strobe.
- `dmem_wen_o`  out  1  write strobe.
- `dmem_addr_o`  out  ADDR_W  word-aligned address `{addr[31:2],2'b00}`.
- `dmem_wdata_o`  out  32  replicated store data: B `{4{b}}`, H `{2{h}}`, W as is.
- `dmem_we_mask_o`  out  4  byte mask: B `0001<<a[1:0]`, H `0011<<a[1:0]`, W `1111`.
- `dmem_rdata_i`  in  32  read data, valid the cycle after `dmem_ren_o`.
- `dmem_resp_i`  in  2  responder status; any nonzero value is an error.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i & req_ready_o`, latch we/op/addr/wdata.
  - Go to ISSUE, or to RESP with error for illegal encodings: op 011/110/111, or store with BU/HU.
- ISSUE: exactly one cycle with `dmem_ren_o` (load) or `dmem_wen_o` (store). Addr/mask/wdata are valid only in this cycle. Load -> CAPTURE; store -> RESP, with err = `|dmem_resp_i`.
- CAPTURE:
  - Sample `dmem_rdata_i`.
  - Shift right by `8*addr[1:0]`.
  - Extend per op: B/H sign-extend, BU/HU zero-extend, W pass through.
  - Register into `resp_rdata_o`; err = `|dmem_resp_i`. Go to RESP.
- RESP:
  - `resp_valid_o`=1.
  - Data and err are held stable until `resp_ready_i`, then go to IDLE.
  - A new request is accepted only from IDLE: no overlap.
- Strobes are 0 in every state except ISSUE. `dmem_ren_o` and `dmem_wen_o` are never high together.

## Timing
- Reset values (applied asynchronously, mid-operation included):
  - State IDLE; `req_ready_o`=1.
  - `resp_valid_o`, `resp_err_o`, `dmem_ren_o`, `dmem_wen_o` = 0.
  - `resp_rdata_o`, `dmem_addr_o`, `dmem_wdata_o`, `dmem_we_mask_o` = 0.
  - An in-flight access is dropped with no response.
- Accept at edge 0. ISSUE is cycle 1. Store `resp_valid_o` is in cycle 2; load `resp_valid_o` is in cycle 3 (minimum, with `resp_ready_i` held high).
- Back-to-back throughput: store 3 cycles, load 4 cycles (the IDLE cycle is included).
- `req_ready_o` is combinational from state only, never from `req_valid_i`.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - H/HU/SH with `addr[0]`=1 and W/SW with `addr[1:0]`≠0 skip ISSUE.
  - Go directly IDLE -> RESP with `resp_err_o`=1 and `resp_rdata_o`=0.
  - No dmem strobe is asserted.
- Undefined:
  - No check. H uses `addr[1]` only, giving mask `0011<<{addr[1],0}`.
  - W ignores `addr[1:0]`.
  - `resp_err_o` comes only from `dmem_resp_i` and from illegal encodings.

## Structure
- Package `lsu_pkg`: op encodings (`LSU_OP_B/H/W/BU/HU`), FSM state enum, `MASK_W`=4.
- Sub-module `lsu_align`: purely combinational. Handles mask generation, wdata replication, and load extract/extend. Instantiated once; reusable by a future ifetch/cache path.

## Test plan
- SW addr 0x8000_0010, data 0xDEAD_BEEF -> ISSUE cycle has `wen`=1, addr 0x8000_0010, mask 1111, wdata 0xDEADBEEF; `resp_valid_o` 2 cycles after accept; err 0.
- SB addr 0x8000_0013, data 0x0000_00A5 -> mask 1000, wdata 0xA5A5A5A5. LB of the same address with `dmem_rdata_i`=0xA5xxxxxx -> `resp_rdata_o`=0xFFFF_FFA5; LBU gives 0x0000_00A5.
- LH addr 0x8000_0002, `dmem_rdata_i`=0x8001_1234 -> `resp_rdata_o`=0xFFFF_8001; LHU gives 0x0000_8001; `resp_valid_o` 3 cycles after accept.
- With macro, LW addr 0x8000_0001 -> no `ren`/`wen`; `resp_valid_o`=1, err=1, rdata 0 in cycle 1. Without macro -> access issued at 0x8000_0000.
- `resp_ready_i` held low 5 cycles -> `resp_valid_o`, data and err stable; `req_ready_o`=0 throughout; new `req_valid_i` not accepted.
- `rst_n_i` low during CAPTURE -> all outputs at reset values immediately; `req_ready_o`=1 after release; the next load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states and
// the encoding legality helper.
package lsu_pkg;

  localparam int MASK_W = 4;

  localparam logic [2:0] LSU_OP_B  = 3'b000;
  localparam logic [2:0] LSU_OP_H  = 3'b001;
  localparam logic [2:0] LSU_OP_W  = 3'b010;
  localparam logic [2:0] LSU_OP_BU = 3'b100;
  localparam logic [2:0] LSU_OP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_e;

  // Unsigned sizes only make sense for loads.
  function automatic logic lsu_op_legal(input logic we, input logic [2:0] op);
    case (op)
      LSU_OP_B, LSU_OP_H, LSU_OP_W: return 1'b1;
      LSU_OP_BU, LSU_OP_HU:         return !we;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: write mask, store-data replication and
// load-data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [1:0]        addr_lo,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  output logic [MASK_W-1:0] we_mask,
  output logic [31:0]       wdata_rep,
  output logic [31:0]       rdata_ext
);

  logic        is_word;
  logic        is_half;
  logic [1:0]  lane;
  logic [31:0] shifted;

  assign is_word = (op[1:0] == 2'b10);
  assign is_half = (op[1:0] == 2'b01);

  // Halves use only addr[1]; words always start at lane 0.
  assign lane    = is_word ? 2'b00 : (is_half ? {addr_lo[1], 1'b0} : addr_lo);
  assign we_mask = is_word ? 4'b1111 : (is_half ? (4'b0011 << lane) : (4'b0001 << lane));
  assign shifted = rdata >> {lane, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < MASK_W; gi++) begin : g_rep
      assign wdata_rep[8*gi +: 8] = is_word ? wdata[8*gi +: 8] :
                                    (is_half ? wdata[8*(gi%2) +: 8] : wdata[7:0]);
    end
  endgenerate

  always_comb begin
    rdata_ext = shifted;
    case (op)
      LSU_OP_B:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      LSU_OP_H:  rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      LSU_OP_BU: rdata_ext = {24'b0, shifted[7:0]};
      LSU_OP_HU: rdata_ext = {16'b0, shifted[15:0]};
      default:   rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store initiator for the data SRAM port: one request at a time,
// IDLE -> ISSUE -> (CAPTURE) -> RESP. Define LSU_MISALIGN_CHECK_EN to fault
// misaligned H/HU/SH/W/SW without touching memory.
module lsu_dmem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              dmem_ren_o,
  output logic              dmem_wen_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  output logic [MASK_W-1:0] dmem_we_mask_o,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic [1:0]        dmem_resp_i
);

  lsu_state_e        state_reg, state_next;
  logic              we_reg, we_next;
  logic [2:0]        op_reg, op_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;

  logic              misalign;
  logic              issue;
  logic [MASK_W-1:0] align_mask;
  logic [DATA_W-1:0] align_wdata;
  logic [DATA_W-1:0] align_rdata;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((req_op_i[1:0] == 2'b01) && req_addr_i[0]) ||
                    ((req_op_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  lsu_align u_align (
    .op        (op_reg),
    .addr_lo   (addr_reg[1:0]),
    .wdata     (wdata_reg),
    .rdata     (dmem_rdata_i),
    .we_mask   (align_mask),
    .wdata_rep (align_wdata),
    .rdata_ext (align_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
      we_reg    <= 1'b0;
      op_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    op_next    = op_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_next    = req_we_i;
          op_next    = req_op_i;
          addr_next  = req_addr_i;
          wdata_next = req_wdata_i;
          rdata_next = '0;
          err_next   = 1'b0;
          if (!lsu_op_legal(req_we_i, req_op_i) || misalign) begin
            err_next   = 1'b1;
            state_next = ST_RESP;
          end else begin
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (we_reg) begin
          err_next   = |dmem_resp_i;
          state_next = ST_RESP;
        end else begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        err_next   = |dmem_resp_i;
        rdata_next = (|dmem_resp_i) ? '0 : align_rdata;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Memory-side outputs are forced to zero outside the single ISSUE cycle.
  assign issue          = (state_reg == ST_ISSUE);
  assign req_ready_o    = (state_reg == ST_IDLE);
  assign dmem_ren_o     = issue && !we_reg;
  assign dmem_wen_o     = issue && we_reg;
  assign dmem_addr_o    = issue ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata_o   = (issue && we_reg) ? align_wdata : '0;
  assign dmem_we_mask_o = (issue && we_reg) ? align_mask : '0;

  assign resp_valid_o = (state_reg == ST_RESP);
  assign resp_rdata_o = rdata_reg;
  assign resp_err_o   = err_reg;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master: a size/offset model predicts every
// cycle of each transaction; literal expectations pin the test-plan vectors.
module tb_lsu_dmem_master;
  import lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_op_i = 3'b000;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        dmem_ren_o;
  logic        dmem_wen_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_we_mask_o;
  logic [31:0] dmem_rdata_i = '0;
  logic [1:0]  dmem_resp_i = '0;

  lsu_dmem_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .dmem_ren_o(dmem_ren_o), .dmem_wen_o(dmem_wen_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_we_mask_o(dmem_we_mask_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_resp_i(dmem_resp_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Synchronous SRAM: data appears the cycle after ren, garbage otherwise.
  logic [31:0] mem_word = '0;
  always @(posedge clk_i) dmem_rdata_i <= dmem_ren_o ? mem_word : 32'($urandom());

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Per-cycle expectations written by the stimulus, compared on every falling edge.
  logic        chk_en = 1'b0;
  logic        exp_ready = 1'b1, exp_rv = 1'b0, exp_ren = 1'b0, exp_wen = 1'b0;
  logic        exp_issue = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_daddr = '0, exp_wd = '0, exp_rd = '0;
  logic [3:0]  exp_mask = '0;

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready_o), 32'(exp_ready));
      chk("resp_valid", 32'(resp_valid_o), 32'(exp_rv));
      chk("dmem_ren", 32'(dmem_ren_o), 32'(exp_ren));
      chk("dmem_wen", 32'(dmem_wen_o), 32'(exp_wen));
      if (exp_issue) begin
        chk("dmem_addr", dmem_addr_o, exp_daddr);
        if (exp_wen) begin
          chk("dmem_we_mask", 32'(dmem_we_mask_o), 32'(exp_mask));
          chk("dmem_wdata", dmem_wdata_o, exp_wd);
        end
      end
      if (exp_rv) begin
        chk("resp_rdata", resp_rdata_o, exp_rd);
        chk("resp_err", 32'(resp_err_o), 32'(exp_err));
      end
    end
  end

  // Access model: size in bytes, lane = address rounded down to the size.
  function automatic void model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] mem, input logic [1:0] rsp,
                                output logic pre_err, output logic [3:0] mask,
                                output logic [31:0] wrep, output logic [31:0] rd, output logic err);
    int size, off;
    logic legal, mis;
    logic [31:0] v, keep;
    legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (!we && (op == 3'd4 || op == 3'd5));
    size  = (op[1:0] == 2'd0) ? 1 : ((op[1:0] == 2'd1) ? 2 : 4);
    mis   = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = (int'(addr[1:0]) % size) != 0;
`endif
    off     = (size == 4) ? 0 : (int'(addr[1:0]) / size) * size;
    pre_err = !legal || mis;
    mask    = 4'(((1 << size) - 1) << off);
    wrep    = (size == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
              ((size == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd);
    v = mem >> (8 * off);
    if (size < 4) begin
      keep = (32'd1 << (8 * size)) - 32'd1;
      v = v & keep;
      if (!op[2] && v[8*size-1]) v = v | ~keep;
    end
    err = pre_err || (rsp != 2'd0);
    rd  = (we || err) ? 32'd0 : v;
  endfunction

  logic [3:0]  obs_mask;
  logic [31:0] obs_wd, obs_daddr, obs_rd;
  logic        obs_err;

  // Entered just after a rising edge with the DUT idle; returns likewise.
  task automatic run_txn(input string nm, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mem,
                         input logic [1:0] rsp, input int stall, input logic poke);
    logic pe, e;
    logic [3:0] m;
    logic [31:0] w, r;
    model(we, op, addr, wd, mem, rsp, pe, m, w, r, e);
    obs_mask = '0; obs_wd = '0; obs_daddr = '0;
    mem_word = mem; dmem_resp_i = rsp;
    req_valid_i = 1'b1; req_we_i = we; req_op_i = op; req_addr_i = addr; req_wdata_i = wd;
    resp_ready_i = 1'b0;
    exp_ready = 1'b1; exp_rv = 1'b0; exp_ren = 1'b0; exp_wen = 1'b0; exp_issue = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i = poke;
    if (poke) begin req_we_i = 1'b1; req_op_i = LSU_OP_W; req_addr_i = 32'h4000_0000; end
    exp_ready = 1'b0;
    if (!pe) begin
      exp_issue = 1'b1; exp_ren = !we; exp_wen = we;
      exp_daddr = {addr[31:2], 2'b00}; exp_mask = m; exp_wd = w;
      @(negedge clk_i);
      obs_mask = dmem_we_mask_o; obs_wd = dmem_wdata_o; obs_daddr = dmem_addr_o;
      @(posedge clk_i); #1;
      exp_issue = 1'b0; exp_ren = 1'b0; exp_wen = 1'b0;
      if (!we) begin @(posedge clk_i); #1; end
    end
    exp_rv = 1'b1; exp_rd = r; exp_err = e;
    for (int k = 0; k <= stall; k++) begin
      resp_ready_i = (k == stall);
      @(negedge clk_i);
      obs_rd = resp_rdata_o; obs_err = resp_err_o;
      @(posedge clk_i); #1;
    end
    resp_ready_i = 1'b0; req_valid_i = 1'b0; dmem_resp_i = '0;
    exp_rv = 1'b0; exp_ready = 1'b1;
    $display("txn %-12s we=%0d op=%0d addr=%08h -> rdata=%08h err=%0d", nm, we, op, addr, obs_rd, obs_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst ready", 32'(req_ready_o), 32'd1);
    chk("rst resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst rdata", resp_rdata_o, 32'd0);
    chk("rst strobes", 32'({dmem_ren_o, dmem_wen_o, resp_err_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    chk_en = 1'b1;
    @(posedge clk_i); #1;

    run_txn("SW", 1'b1, LSU_OP_W, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 2'd0, 0, 1'b0);
    chk("SW mask", 32'(obs_mask), 32'hF);
    chk("SW wdata", obs_wd, 32'hDEAD_BEEF);
    chk("SW addr", obs_daddr, 32'h8000_0010);
    chk("SW err", 32'(obs_err), 32'd0);

    run_txn("SB", 1'b1, LSU_OP_B, 32'h8000_0013, 32'h0000_00A5, 32'h0, 2'd0, 0, 1'b0);
    chk("SB mask", 32'(obs_mask), 32'h8);
    chk("SB wdata", obs_wd, 32'hA5A5_A5A5);

    run_txn("LB", 1'b0, LSU_OP_B, 32'h8000_0013, 32'h0, 32'hA512_3456, 2'd0, 0, 1'b0);
    chk("LB rdata", obs_rd, 32'hFFFF_FFA5);
    run_txn("LBU", 1'b0, LSU_OP_BU, 32'h8000_0013, 32'h0, 32'hA512_3456, 2'd0, 0, 1'b0);
    chk("LBU rdata", obs_rd, 32'h0000_00A5);

    run_txn("LH", 1'b0, LSU_OP_H, 32'h8000_0002, 32'h0, 32'h8001_1234, 2'd0, 0, 1'b0);
    chk("LH rdata", obs_rd, 32'hFFFF_8001);
    run_txn("LHU", 1'b0, LSU_OP_HU, 32'h8000_0002, 32'h0, 32'h8001_1234, 2'd0, 0, 1'b0);
    chk("LHU rdata", obs_rd, 32'h0000_8001);

    run_txn("SH", 1'b1, LSU_OP_H, 32'h8000_0006, 32'h1234_ABCD, 32'h0, 2'd0, 0, 1'b0);
    chk("SH mask", 32'(obs_mask), 32'hC);
    chk("SH wdata", obs_wd, 32'hABCD_ABCD);

    run_txn("LW mis", 1'b0, LSU_OP_W, 32'h8000_0001, 32'h0, 32'h1122_3344, 2'd0, 0, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("LW mis err", 32'(obs_err), 32'd1);
    chk("LW mis rdata", obs_rd, 32'd0);
`else
    chk("LW mis addr", obs_daddr, 32'h8000_0000);
    chk("LW mis rdata", obs_rd, 32'h1122_3344);
`endif

    run_txn("LH odd", 1'b0, LSU_OP_H, 32'h8000_0001, 32'h0, 32'h0000_F00D, 2'd0, 0, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("LH odd err", 32'(obs_err), 32'd1);
`else
    chk("LH odd rdata", obs_rd, 32'hFFFF_F00D);
`endif

    run_txn("SBU illegal", 1'b1, LSU_OP_BU, 32'h8000_0000, 32'h55, 32'h0, 2'd0, 0, 1'b0);
    chk("SBU err", 32'(obs_err), 32'd1);
    run_txn("op011", 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 2'd0, 0, 1'b0);
    chk("op011 err", 32'(obs_err), 32'd1);
    chk("op011 rdata", obs_rd, 32'd0);

    run_txn("LW rsp err", 1'b0, LSU_OP_W, 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 2'd2, 0, 1'b0);
    chk("LW rsp err", 32'(obs_err), 32'd1);
    chk("LW rsp rdata", obs_rd, 32'd0);
    run_txn("SW rsp err", 1'b1, LSU_OP_W, 32'h8000_0024, 32'h1, 32'h0, 2'd1, 0, 1'b0);
    chk("SW rsp err", 32'(obs_err), 32'd1);

    run_txn("LB stall", 1'b0, LSU_OP_B, 32'h8000_0000, 32'h0, 32'h1234_567F, 2'd0, 5, 1'b1);
    chk("LB stall rdata", obs_rd, 32'h0000_007F);

    // Reset asserted while a load sits in CAPTURE.
    chk_en = 1'b0;
    mem_word = 32'h9999_9999;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_op_i = LSU_OP_B; req_addr_i = 32'h8000_0001;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    #1;
    chk("async rst ready", 32'(req_ready_o), 32'd1);
    chk("async rst resp_valid", 32'(resp_valid_o), 32'd0);
    chk("async rst err", 32'(resp_err_o), 32'd0);
    chk("async rst rdata", resp_rdata_o, 32'd0);
    chk("async rst ren/wen", 32'({dmem_ren_o, dmem_wen_o}), 32'd0);
    chk("async rst addr", dmem_addr_o, 32'd0);
    chk("async rst wdata", dmem_wdata_o, 32'd0);
    chk("async rst mask", 32'(dmem_we_mask_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      chk("post rst ready", 32'(req_ready_o), 32'd1);
      chk("post rst no resp", 32'(resp_valid_o), 32'd0);
    end
    @(posedge clk_i); #1;
    exp_ready = 1'b1; exp_rv = 1'b0; exp_ren = 1'b0; exp_wen = 1'b0; exp_issue = 1'b0;
    chk_en = 1'b1;

    run_txn("LW post rst", 1'b0, LSU_OP_W, 32'h8000_0040, 32'h0, 32'h0BAD_F00D, 2'd0, 0, 1'b0);
    chk("LW post rst rdata", obs_rd, 32'h0BAD_F00D);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
